// File: rtl/btb_predictor_pkg.sv
// rtl/btb_predictor_pkg.sv - shared fetch-predictor types for the BTB and BHT
//
// Purpose: request/response/update/entry types used by btb_predictor and the
//          testbench, plus a small slot-mask helper.
// Ports:   none (package).
package Bundle;

    localparam int BTB_XLEN         = 32;
    localparam int BTB_FETCH_WIDTH  = 4;
    localparam int BTB_BRIDX_BITS   = $clog2(BTB_FETCH_WIDTH);
    localparam int BTB_OPAQUE_BITS  = 10;
    localparam int BTB_HISTORY_BITS = 6;
    localparam int BTB_TAG_BITS     = BTB_XLEN - 2 - BTB_BRIDX_BITS;

    typedef struct packed {
        logic [BTB_XLEN-1:0] addr;
        logic                valid;
    } BTBRequest;

    typedef struct packed {
        logic [BTB_HISTORY_BITS-1:0] history;
        logic [1:0]                  value;
    } BHTResp;

    typedef struct packed {
        logic                       valid;
        logic                       taken;
        logic [BTB_BRIDX_BITS-1:0]  bridx;
        logic [BTB_XLEN-1:0]        target;
        logic [BTB_OPAQUE_BITS-1:0] entry;
        BHTResp                     bht;
        logic [BTB_FETCH_WIDTH-1:0] mask;
    } BTBResponse;

    typedef struct packed {
        logic                        valid;
        logic [BTB_XLEN-1:0]         pc;
        logic [BTB_BRIDX_BITS-1:0]   bridx;
        logic [BTB_XLEN-1:0]         target;
        logic                        taken;
        logic                        is_jump;
        logic [BTB_HISTORY_BITS-1:0] history;
    } BTBUpdate;

    typedef struct packed {
        logic                      valid;
        logic [BTB_TAG_BITS-1:0]   tag;
        logic [BTB_BRIDX_BITS-1:0] bridx;
        logic [BTB_XLEN-1:0]       target;
        logic                      is_jump;
    } BTBEntryState;

    // Contiguous run of set bits covering slots first..last inclusive.
    function automatic logic [BTB_FETCH_WIDTH-1:0] slot_mask(
        input logic [BTB_BRIDX_BITS-1:0] first,
        input logic [BTB_BRIDX_BITS-1:0] last
    );
        logic [BTB_FETCH_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < BTB_FETCH_WIDTH; i++) begin
            m[i] = (i >= int'(first)) && (i <= int'(last));
        end
        return m;
    endfunction

endpackage

// File: rtl/btb_predictor_bht.sv
// rtl/btb_predictor_bht.sv - gshare 2-bit counter table with global history
//
// Purpose: holds the saturating counter array and the non-speculative global
//          history; hashes PC bits with history for both read and train.
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   lookup_pc_idx_i      fetch PC bits [HISTORY_BITS+1:2]
//   lookup_value_o       counter selected by lookup_pc_idx_i ^ ghist
//   lookup_history_o     current ghist
//   train_valid_i        train one counter and shift ghist
//   train_pc_idx_i       resolved PC bits [HISTORY_BITS+1:2]
//   train_taken_i        resolved direction
//   train_history_i      history captured at prediction time
module bht_counters #(
    parameter int HISTORY_BITS = 6,
    parameter int BHT_ENTRIES  = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [HISTORY_BITS-1:0] lookup_pc_idx_i,
    output logic [1:0]              lookup_value_o,
    output logic [HISTORY_BITS-1:0] lookup_history_o,
    input  logic                    train_valid_i,
    input  logic [HISTORY_BITS-1:0] train_pc_idx_i,
    input  logic                    train_taken_i,
    input  logic [HISTORY_BITS-1:0] train_history_i
);

    logic [1:0]              cnt_q [BHT_ENTRIES];
    logic [1:0]              cnt_d [BHT_ENTRIES];
    logic [HISTORY_BITS-1:0] ghist_q, ghist_d;
    logic [HISTORY_BITS-1:0] lookup_idx, train_idx;
    logic [1:0]              train_cnt;

    assign lookup_idx       = lookup_pc_idx_i ^ ghist_q;
    assign lookup_value_o   = cnt_q[lookup_idx];
    assign lookup_history_o = ghist_q;

    // Training uses the history that produced the prediction, not the live one.
    assign train_idx = train_pc_idx_i ^ train_history_i;
    assign train_cnt = cnt_q[train_idx];

    always_comb begin
        cnt_d   = cnt_q;
        ghist_d = ghist_q;
        if (train_valid_i) begin
            if (train_taken_i) begin
                if (train_cnt != 2'b11) cnt_d[train_idx] = train_cnt + 2'd1;
            end else begin
                if (train_cnt != 2'b00) cnt_d[train_idx] = train_cnt - 2'd1;
            end
            ghist_d = {ghist_q[HISTORY_BITS-2:0], train_taken_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) cnt_q[i] <= 2'b01;
            ghist_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            ghist_q <= ghist_d;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - fully associative BTB with gshare direction predictor
//
// Purpose: one lookup per cycle with a registered prediction, trained from
//          resolved branches; round-robin allocation, flushable valid bits.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req                  fetch PC and lookup strobe
//   resp                 registered prediction for last cycle's req
//   upd_*                resolved-branch training interface
//   flush                invalidate every BTB entry
module btb_predictor
    import Bundle::*;
#(
    parameter int ENTRIES      = 16,
    parameter int FETCH_WIDTH  = 4,
    parameter int OPAQUE_BITS  = 10,
    parameter int HISTORY_BITS = 6,
    parameter int BHT_ENTRIES  = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  BTBRequest                      req,
    output BTBResponse                     resp,
    input  logic                           upd_valid,
    input  logic [31:0]                    upd_pc,
    input  logic [$clog2(FETCH_WIDTH)-1:0] upd_bridx,
    input  logic [31:0]                    upd_target,
    input  logic                           upd_taken,
    input  logic                           upd_is_jump,
    input  logic [HISTORY_BITS-1:0]        upd_history,
    input  logic                           flush
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int OFF_BITS = $clog2(FETCH_WIDTH);

    BTBUpdate     upd;
    BTBEntryState entries_q [ENTRIES];
    BTBEntryState entries_d [ENTRIES];
    logic [IDX_BITS-1:0] ptr_q, ptr_d;
    BTBResponse   resp_q, resp_d;

    assign upd = '{valid: upd_valid, pc: upd_pc, bridx: upd_bridx,
                   target: upd_target, taken: upd_taken,
                   is_jump: upd_is_jump, history: upd_history};

    // Byte-offset bits never affect prediction.
    logic unused_bits;
    assign unused_bits = ^{req.addr[1:0], upd.pc[1:0]};

    // ---------------- lookup ----------------
    logic [BTB_TAG_BITS-1:0] lk_tag;
    logic [OFF_BITS-1:0]     lk_off;
    logic                    lk_hit;
    logic [IDX_BITS-1:0]     lk_idx;
    logic [1:0]              bht_value;
    logic [HISTORY_BITS-1:0] bht_history;

    assign lk_tag = req.addr[31:2+OFF_BITS];
    assign lk_off = req.addr[1+OFF_BITS:2];

    // A branch earlier in the packet than the fetch offset is not reachable.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entries_q[i].valid && entries_q[i].tag == lk_tag &&
                entries_q[i].bridx >= lk_off) begin
                lk_hit = 1'b1;
                lk_idx = IDX_BITS'(i);
            end
        end
    end

    bht_counters #(
        .HISTORY_BITS (HISTORY_BITS),
        .BHT_ENTRIES  (BHT_ENTRIES)
    ) u_bht (
        .clk_i            (clk),
        .reset_i          (reset),
        .lookup_pc_idx_i  (req.addr[HISTORY_BITS+1:2]),
        .lookup_value_o   (bht_value),
        .lookup_history_o (bht_history),
        .train_valid_i    (upd.valid && !upd.is_jump),
        .train_pc_idx_i   (upd.pc[HISTORY_BITS+1:2]),
        .train_taken_i    (upd.taken),
        .train_history_i  (upd.history)
    );

    always_comb begin
        resp_d = '0;
        if (req.valid) begin
            resp_d.valid = 1'b1;
            resp_d.taken = lk_hit && (entries_q[lk_idx].is_jump || bht_value[1]);
            if (lk_hit) begin
                resp_d.bridx  = entries_q[lk_idx].bridx;
                resp_d.target = entries_q[lk_idx].target;
                resp_d.entry  = OPAQUE_BITS'(lk_idx);
            end
            resp_d.bht.history = bht_history;
            resp_d.bht.value   = bht_value;
            resp_d.mask = resp_d.taken ? slot_mask(lk_off, entries_q[lk_idx].bridx)
                                       : slot_mask(lk_off, '1);
        end
    end

    // ---------------- update ----------------
    logic [BTB_TAG_BITS-1:0] up_tag;
    logic                    up_hit;
    logic [IDX_BITS-1:0]     up_idx;

    assign up_tag = upd.pc[31:2+OFF_BITS];

    // Presence is by tag alone, so a tag never occupies two entries.
    always_comb begin
        up_hit = 1'b0;
        up_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entries_q[i].valid && entries_q[i].tag == up_tag) begin
                up_hit = 1'b1;
                up_idx = IDX_BITS'(i);
            end
        end
    end

    // Flush dominates: a coincident write and its pointer advance are dropped.
    always_comb begin
        entries_d = entries_q;
        ptr_d     = ptr_q;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
        end else if (upd.valid && upd.taken) begin
            if (up_hit) begin
                entries_d[up_idx].bridx   = upd.bridx;
                entries_d[up_idx].target  = upd.target;
                entries_d[up_idx].is_jump = upd.is_jump;
            end else begin
                entries_d[ptr_q] = '{valid: 1'b1, tag: up_tag, bridx: upd.bridx,
                                     target: upd.target, is_jump: upd.is_jump};
                ptr_d = ptr_q + IDX_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
            ptr_q  <= '0;
            resp_q <= '0;
        end else begin
            entries_q <= entries_d;
            ptr_q     <= ptr_d;
            resp_q    <= resp_d;
        end
    end

    assign resp = resp_q;

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - directed scoreboard bench for btb_predictor
module tb_btb_predictor;
    import Bundle::*;

    logic        clk = 1'b0;
    logic        reset;
    BTBRequest   req;
    BTBResponse  resp;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_bridx;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_is_jump;
    logic [5:0]  upd_history;
    logic        flush;

    always #5 clk = ~clk;

    btb_predictor #(
        .ENTRIES(16), .FETCH_WIDTH(4), .OPAQUE_BITS(10),
        .HISTORY_BITS(6), .BHT_ENTRIES(64)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .resp(resp),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_bridx(upd_bridx),
        .upd_target(upd_target), .upd_taken(upd_taken),
        .upd_is_jump(upd_is_jump), .upd_history(upd_history), .flush(flush)
    );

    BTBResponse exp_q[$];
    BTBResponse none_r;
    int checks = 0;
    int passed = 0;

    function automatic BTBResponse rsp(input logic t, input logic [1:0] bi,
                                       input logic [31:0] tg, input logic [9:0] en,
                                       input logic [5:0] h, input logic [1:0] v,
                                       input logic [3:0] m);
        BTBResponse r;
        r.valid = 1'b1; r.taken = t; r.bridx = bi; r.target = tg; r.entry = en;
        r.bht.history = h; r.bht.value = v; r.mask = m;
        return r;
    endfunction

    task automatic clear_inputs();
        req = '0; upd_valid = 0; upd_pc = '0; upd_bridx = '0; upd_target = '0;
        upd_taken = 0; upd_is_jump = 0; upd_history = '0; flush = 0;
    endtask

    task automatic set_req(input logic [31:0] a);
        req.addr = a; req.valid = 1'b1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic [1:0] bi, input logic [31:0] tg,
                           input logic tk, input logic jmp, input logic [5:0] h);
        upd_valid = 1; upd_pc = pc; upd_bridx = bi; upd_target = tg;
        upd_taken = tk; upd_is_jump = jmp; upd_history = h;
    endtask

    // Expected response is queued with the stimulus and retired after the edge.
    task automatic tick(input string name, input BTBResponse e);
        BTBResponse exp_r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        exp_r = exp_q.pop_front();
        checks++;
        assert (resp === exp_r) passed++;
        else $error("FAIL %s: observed %h expected %h", name, resp, exp_r);
        clear_inputs();
    endtask

    initial begin
        none_r = '0;
        clear_inputs();
        reset = 1;
        set_req(32'h100);
        tick("reset0", none_r);
        tick("reset1", none_r);
        reset = 0;

        set_req(32'h100);
        tick("cold_miss", rsp(0, 2'd0, 32'h0, 10'd0, 6'h00, 2'b01, 4'b1111));

        set_upd(32'h100, 2'd2, 32'h400, 1, 1, 6'h00);
        tick("idle_after_upd", none_r);
        set_req(32'h104);
        tick("jump_hit", rsp(1, 2'd2, 32'h400, 10'd0, 6'h00, 2'b01, 4'b0110));
        set_req(32'h10C);
        tick("past_bridx_miss", rsp(0, 2'd0, 32'h0, 10'd0, 6'h00, 2'b01, 4'b1000));

        // Counter 0x0E trained; probes choose addresses indexing it under live ghist.
        set_upd(32'h200, 2'd0, 32'h300, 1, 0, 6'h0E);
        tick("train1", none_r);
        set_req(32'h3C);
        tick("cnt_2", rsp(0, 2'd0, 32'h0, 10'd0, 6'h01, 2'b10, 4'b1000));
        set_upd(32'h200, 2'd0, 32'h300, 1, 0, 6'h0E);
        tick("train2", none_r);
        set_req(32'h34);
        tick("cnt_3", rsp(0, 2'd0, 32'h0, 10'd0, 6'h03, 2'b11, 4'b1110));
        set_upd(32'h200, 2'd0, 32'h300, 1, 0, 6'h0E);
        tick("train3", none_r);
        set_req(32'h24);
        tick("cnt_sat", rsp(0, 2'd0, 32'h0, 10'd0, 6'h07, 2'b11, 4'b1110));
        set_upd(32'h200, 2'd0, 32'h999, 0, 0, 6'h0E);
        tick("train_nt", none_r);
        set_req(32'h200);
        tick("cond_hit_cnt2", rsp(1, 2'd0, 32'h300, 10'd1, 6'h0E, 2'b10, 4'b0001));

        // 17 allocations from pointer 2: first one is evicted by the wrap.
        for (int k = 0; k < 17; k++) begin
            set_upd(32'h1000 + 32'(k * 16), 2'd3, 32'h2000 + 32'(k * 4), 1, 1, 6'h00);
            tick("alloc", none_r);
        end
        for (int k = 0; k < 17; k++) begin
            logic [1:0] v;
            v = (((k * 4) % 64) == 0) ? 2'b10 : 2'b01;
            set_req(32'h1000 + 32'(k * 16));
            if (k == 0)
                tick("rr_evicted", rsp(0, 2'd0, 32'h0, 10'd0, 6'h0E, v, 4'b1111));
            else
                tick("rr_hit", rsp(1, 2'd3, 32'h2000 + 32'(k * 4), 10'((2 + k) % 16),
                                   6'h0E, v, 4'b1111));
        end

        flush = 1;
        set_upd(32'h3000, 2'd1, 32'h3100, 1, 0, 6'h05);
        set_req(32'h1010);
        tick("pre_flush_view", rsp(1, 2'd3, 32'h2004, 10'd3, 6'h0E, 2'b01, 4'b1111));
        set_req(32'h3000);
        tick("flush_drop_alloc", rsp(0, 2'd0, 32'h0, 10'd0, 6'h1D, 2'b01, 4'b1111));
        set_req(32'h1010);
        tick("flushed_miss", rsp(0, 2'd0, 32'h0, 10'd0, 6'h1D, 2'b01, 4'b1111));
        set_req(32'h60);
        tick("flush_bht_trained", rsp(0, 2'd0, 32'h0, 10'd0, 6'h1D, 2'b10, 4'b1111));

        set_upd(32'h5000, 2'd0, 32'h5500, 1, 1, 6'h00);
        set_req(32'h5000);
        tick("same_cycle_miss", rsp(0, 2'd0, 32'h0, 10'd0, 6'h1D, 2'b01, 4'b1111));
        set_req(32'h5000);
        tick("next_cycle_hit", rsp(1, 2'd0, 32'h5500, 10'd3, 6'h1D, 2'b01, 4'b0001));

        reset = 1;
        set_req(32'h5000);
        tick("reset_discard", none_r);
        reset = 0;
        set_req(32'h5000);
        tick("post_reset_miss", rsp(0, 2'd0, 32'h0, 10'd0, 6'h00, 2'b01, 4'b1111));
        tick("idle_zero", none_r);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
